// File: rtl/axi_lite_slave_adapter_if.sv
// AXI4-Lite slave-side bus plus the simple valid/ready memory port of axi_lite_slave_adapter.
interface axi_lite_slave_adapter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR_i;
  logic              AWVALID_i;
  logic              AWREADY_o;
  logic [DATA_W-1:0] WDATA_i;
  logic [STRB_W-1:0] WSTRB_i;
  logic              WVALID_i;
  logic              WREADY_o;
  logic [1:0]        BRESP_o;
  logic              BVALID_o;
  logic              BREADY_i;
  logic [ADDR_W-1:0] ARADDR_i;
  logic              ARVALID_i;
  logic              ARREADY_o;
  logic [DATA_W-1:0] RDATA_o;
  logic [1:0]        RRESP_o;
  logic              RVALID_o;
  logic              RREADY_i;
  logic              mem_valid_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [STRB_W-1:0] mem_wstrb_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  AWADDR_i, AWVALID_i, WDATA_i, WSTRB_i, WVALID_i, BREADY_i,
    input  ARADDR_i, ARVALID_i, RREADY_i, mem_ready_i, mem_rdata_i,
    output AWREADY_o, WREADY_o, BRESP_o, BVALID_o, ARREADY_o, RDATA_o, RRESP_o, RVALID_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output AWADDR_i, AWVALID_i, WDATA_i, WSTRB_i, WVALID_i, BREADY_i,
    output ARADDR_i, ARVALID_i, RREADY_i, mem_ready_i, mem_rdata_i,
    input  AWREADY_o, WREADY_o, BRESP_o, BVALID_o, ARREADY_o, RDATA_o, RRESP_o, RVALID_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/axi_lite_slave_adapter.sv
// AXI4-Lite slave that replays one transaction at a time onto a simple valid/ready memory port.
// Optional memory wait timeout with SLVERR response: define AXIL_SLV_TIMEOUT_EN.
module axi_lite_slave_adapter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                    clk_i,
  input logic                    rst_i,
  axi_lite_slave_adapter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = $clog2(STRB_W);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_COLLECT = 3'd1;
  localparam logic [2:0] S_MEM_WR     = 3'd2;
  localparam logic [2:0] S_WR_RESP    = 3'd3;
  localparam logic [2:0] S_MEM_RD     = 3'd4;
  localparam logic [2:0] S_RD_RESP    = 3'd5;

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axi_lite_slave_adapter: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi_lite_slave_adapter: TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    word_align = a & ({ADDR_W{1'b1}} << LSB_W);
  endfunction

  logic [2:0]        state_r;
  logic              last_wr_r, aw_got_r, w_got_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [STRB_W-1:0] wstrb_r;
  logic              bvalid_r, rvalid_r, mem_valid_r;
  logic [1:0]        bresp_r, rresp_r;
  logic [DATA_W-1:0] rdata_r, mem_wdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [STRB_W-1:0] mem_wstrb_r;

  logic              grant_wr_s, grant_rd_s, aw_hs_s, w_hs_s, wr_done_s, timeout_s;
  logic [ADDR_W-1:0] awaddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [STRB_W-1:0] wstrb_s;

`ifdef AXIL_SLV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // Memory wait counter, cleared outside the memory states
  always_ff @(posedge clk_i) begin
    if (rst_i || !(state_r == S_MEM_WR || state_r == S_MEM_RD)) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (!bus.mem_ready_i) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = !bus.mem_ready_i && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // IDLE arbitration, AW/W capture qualifiers and merged write payload
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (state_r == S_IDLE) begin
      grant_wr_s = (bus.AWVALID_i | bus.WVALID_i) & (!bus.ARVALID_i | !last_wr_r);
      grant_rd_s = bus.ARVALID_i & !grant_wr_s;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
    aw_hs_s   = (state_r == S_WR_COLLECT) & !aw_got_r & bus.AWVALID_i;
    w_hs_s    = (state_r == S_WR_COLLECT) & !w_got_r & bus.WVALID_i;
    wr_done_s = (aw_got_r | aw_hs_s) & (w_got_r | w_hs_s);
    awaddr_s  = aw_got_r ? awaddr_r : bus.AWADDR_i;
    wdata_s   = w_got_r ? wdata_r : bus.WDATA_i;
    wstrb_s   = w_got_r ? wstrb_r : bus.WSTRB_i;
  end

  assign bus.ARREADY_o  = grant_rd_s;
  assign bus.AWREADY_o  = (state_r == S_WR_COLLECT) & !aw_got_r;
  assign bus.WREADY_o   = (state_r == S_WR_COLLECT) & !w_got_r;
  assign bus.BVALID_o   = bvalid_r;
  assign bus.BRESP_o    = bresp_r;
  assign bus.RVALID_o   = rvalid_r;
  assign bus.RRESP_o    = rresp_r;
  assign bus.RDATA_o    = rdata_r;
  assign bus.mem_valid_o = mem_valid_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;
  assign bus.mem_wstrb_o = mem_wstrb_r;

  // Transaction FSM; memory request outputs are loaded on the edge that enters MEM_WR/MEM_RD
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;    last_wr_r <= 1'b0;   aw_got_r <= 1'b0;  w_got_r <= 1'b0;
      awaddr_r <= '0;       wdata_r <= '0;       wstrb_r <= '0;
      bvalid_r <= 1'b0;     bresp_r <= 2'b00;    rvalid_r <= 1'b0;  rresp_r <= 2'b00;
      rdata_r <= '0;        mem_valid_r <= 1'b0; mem_addr_r <= '0;
      mem_wdata_r <= '0;    mem_wstrb_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_wr_s) begin
            state_r <= S_WR_COLLECT;
          end else if (grant_rd_s) begin
            mem_valid_r <= 1'b1;
            mem_addr_r  <= word_align(bus.ARADDR_i);
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
            state_r     <= S_MEM_RD;
          end
        end
        S_WR_COLLECT: begin
          if (aw_hs_s) begin
            aw_got_r <= 1'b1;
            awaddr_r <= bus.AWADDR_i;
          end
          if (w_hs_s) begin
            w_got_r <= 1'b1;
            wdata_r <= bus.WDATA_i;
            wstrb_r <= bus.WSTRB_i;
          end
          if (wr_done_s) begin
            aw_got_r    <= 1'b0;
            w_got_r     <= 1'b0;
            mem_valid_r <= 1'b1;
            mem_addr_r  <= word_align(awaddr_s);
            mem_wdata_r <= wdata_s;
            mem_wstrb_r <= wstrb_s;
            state_r     <= S_MEM_WR;
          end
        end
        S_MEM_WR: begin
          if (bus.mem_ready_i || timeout_s) begin
            mem_valid_r <= 1'b0; mem_addr_r <= '0; mem_wdata_r <= '0; mem_wstrb_r <= '0;
            bvalid_r    <= 1'b1;
            bresp_r     <= bus.mem_ready_i ? 2'b00 : 2'b10;
            state_r     <= S_WR_RESP;
          end
        end
        S_MEM_RD: begin
          if (bus.mem_ready_i || timeout_s) begin
            mem_valid_r <= 1'b0; mem_addr_r <= '0; mem_wdata_r <= '0; mem_wstrb_r <= '0;
            rvalid_r    <= 1'b1;
            rresp_r     <= bus.mem_ready_i ? 2'b00 : 2'b10;
            rdata_r     <= bus.mem_ready_i ? bus.mem_rdata_i : '0;
            state_r     <= S_RD_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.BREADY_i) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            last_wr_r <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        S_RD_RESP: begin
          if (bus.RREADY_i) begin
            rvalid_r  <= 1'b0;
            rresp_r   <= 2'b00;
            rdata_r   <= '0;
            last_wr_r <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;    last_wr_r <= 1'b0;   aw_got_r <= 1'b0;  w_got_r <= 1'b0;
          awaddr_r <= '0;       wdata_r <= '0;       wstrb_r <= '0;
          bvalid_r <= 1'b0;     bresp_r <= 2'b00;    rvalid_r <= 1'b0;  rresp_r <= 2'b00;
          rdata_r <= '0;        mem_valid_r <= 1'b0; mem_addr_r <= '0;
          mem_wdata_r <= '0;    mem_wstrb_r <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_adapter.sv
// Directed self-checking bench for axi_lite_slave_adapter (covers AXIL_SLV_TIMEOUT_EN both ways).
module tb_axi_lite_slave_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_slave_adapter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_slave_adapter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder controls
  int          mem_wait = 0;
  bit          mem_hold = 1'b0;
  int          wait_cnt = 0;

  // completed memory operations, recorded at the completing edge
  int          op_cnt = 0;
  logic        op_wr   [0:63];
  logic [31:0] op_addr [0:63];
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  always @(posedge clk) begin
    if (bus.mem_valid_o && bus.mem_ready_i) begin
      op_wr[op_cnt[5:0]]   <= |bus.mem_wstrb_o;
      op_addr[op_cnt[5:0]] <= bus.mem_addr_o;
      last_wdata           <= bus.mem_wdata_o;
      last_wstrb           <= bus.mem_wstrb_o;
      op_cnt               <= op_cnt + 1;
    end
  end

  initial begin
    bus.mem_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_valid_o && !mem_hold) begin
        if (wait_cnt == mem_wait) begin
          bus.mem_ready_i = 1'b1;
        end else begin
          bus.mem_ready_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ready_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int n;
  int base;

  initial begin
    bus.AWADDR_i = '0; bus.AWVALID_i = 1'b0; bus.WDATA_i = '0; bus.WSTRB_i = '0;
    bus.WVALID_i = 1'b0; bus.BREADY_i = 1'b0; bus.ARADDR_i = '0; bus.ARVALID_i = 1'b0;
    bus.RREADY_i = 1'b0; bus.mem_rdata_i = '0;
    repeat (2) tick();

    // reset state
    @(negedge clk);
    check("rst_bvalid", bus.BVALID_o, 1'b0);
    check("rst_rvalid", bus.RVALID_o, 1'b0);
    check("rst_bresp", bus.BRESP_o, 2'b00);
    check("rst_rresp", bus.RRESP_o, 2'b00);
    check("rst_rdata", bus.RDATA_o, 32'h0);
    check("rst_mem_valid", bus.mem_valid_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_mem_wstrb", bus.mem_wstrb_o, 4'h0);
    check("rst_readies", {bus.AWREADY_o, bus.WREADY_o, bus.ARREADY_o}, 3'b000);
    tick();
    rst = 1'b0;

    // write: AW and W together, zero-wait memory, BREADY held low 3 cycles
    mem_wait = 0;
    bus.AWADDR_i = 32'h10; bus.AWVALID_i = 1'b1;
    bus.WDATA_i = 32'hDEADBEEF; bus.WSTRB_i = 4'hF; bus.WVALID_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.AWREADY_o && bus.WREADY_o) && n < 10) begin @(negedge clk); n++; end
    check("t1_aw_w_ready", {bus.AWREADY_o, bus.WREADY_o}, 2'b11);
    tick();
    bus.AWVALID_i = 1'b0; bus.WVALID_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.BVALID_o && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      check("t1_bvalid_hold", bus.BVALID_o, 1'b1);
      check("t1_bresp_hold", bus.BRESP_o, 2'b00);
      if (i < 2) @(negedge clk);
    end
    tick();
    bus.BREADY_i = 1'b1;
    tick();
    bus.BREADY_i = 1'b0;
    @(negedge clk);
    check("t1_bvalid_clear", bus.BVALID_o, 1'b0);
    check("t1_mem_ops", op_cnt, 1);
    check("t1_mem_is_wr", op_wr[0], 1'b1);
    check("t1_mem_addr", op_addr[0], 32'h10);
    check("t1_mem_wdata", last_wdata, 32'hDEADBEEF);
    check("t1_mem_wstrb", last_wstrb, 4'hF);

    // write: W two cycles ahead of AW
    tick();
    bus.BREADY_i = 1'b1;
    bus.WDATA_i = 32'h0000AAAA; bus.WSTRB_i = 4'b0011; bus.WVALID_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.WREADY_o && n < 10) begin @(negedge clk); n++; end
    check("t2_wready", bus.WREADY_o, 1'b1);
    tick();
    bus.WVALID_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_wready_low", bus.WREADY_o, 1'b0);
      check("t2_awready_high", bus.AWREADY_o, 1'b1);
    end
    tick();
    bus.AWADDR_i = 32'h24; bus.AWVALID_i = 1'b1;
    tick();
    bus.AWVALID_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.BVALID_o && n < 20) begin @(negedge clk); n++; end
    check("t2_bvalid", bus.BVALID_o, 1'b1);
    tick();
    bus.BREADY_i = 1'b0;
    check("t2_mem_ops", op_cnt, 2);
    check("t2_mem_addr", op_addr[1], 32'h24);
    check("t2_mem_wstrb", last_wstrb, 4'b0011);
    check("t2_mem_wdata", last_wdata, 32'h0000AAAA);

    // read of unaligned 0x107 with 3 memory wait cycles
    mem_wait = 3;
    bus.mem_rdata_i = 32'h12345678;
    bus.ARADDR_i = 32'h107; bus.ARVALID_i = 1'b1;
    @(negedge clk);
    check("t3_arready", bus.ARREADY_o, 1'b1);
    tick();
    bus.ARVALID_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.mem_valid_o && n < 20) begin
      if (n == 0) begin
        check("t3_mem_addr", bus.mem_addr_o, 32'h104);
        check("t3_mem_wstrb", bus.mem_wstrb_o, 4'h0);
        check("t3_mem_wdata", bus.mem_wdata_o, 32'h0);
      end
      n++;
      @(negedge clk);
    end
    check("t3_mem_valid_cycles", n, 4);
    check("t3_rvalid", bus.RVALID_o, 1'b1);
    check("t3_rdata", bus.RDATA_o, 32'h12345678);
    check("t3_rresp", bus.RRESP_o, 2'b00);
    tick();
    bus.RREADY_i = 1'b1;
    tick();
    bus.RREADY_i = 1'b0;
    @(negedge clk);
    check("t3_rvalid_clear", bus.RVALID_o, 1'b0);
    check("t3_rdata_clear", bus.RDATA_o, 32'h0);

    // arbitration ties after reset alternate W,R,W,R
    tick();
    do_reset();
    base = op_cnt;
    mem_wait = 0;
    bus.BREADY_i = 1'b1; bus.RREADY_i = 1'b1;
    bus.ARADDR_i = 32'h40; bus.ARVALID_i = 1'b1;
    bus.AWADDR_i = 32'h80; bus.AWVALID_i = 1'b1;
    bus.WDATA_i = 32'h11112222; bus.WSTRB_i = 4'hF; bus.WVALID_i = 1'b1;
    n = 0;
    while (op_cnt < base + 4 && n < 80) begin tick(); n++; end
    bus.ARVALID_i = 1'b0; bus.AWVALID_i = 1'b0; bus.WVALID_i = 1'b0;
    bus.BREADY_i = 1'b0; bus.RREADY_i = 1'b0;
    do_reset();
    check("t4_op_count", (op_cnt >= base + 4), 1'b1);
    check("t4_order", {op_wr[base[5:0]], op_wr[6'(base + 1)], op_wr[6'(base + 2)], op_wr[6'(base + 3)]}, 4'b1010);
    check("t4_first_addr", op_addr[base[5:0]], 32'h80);
    check("t4_second_addr", op_addr[6'(base + 1)], 32'h40);

    // reset pulsed while in MEM_RD
    mem_hold = 1'b1;
    base = op_cnt;
    bus.ARADDR_i = 32'h200; bus.ARVALID_i = 1'b1;
    tick();
    bus.ARVALID_i = 1'b0;
    @(negedge clk);
    check("t5_mem_valid_before", bus.mem_valid_o, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_mem_valid_rst", bus.mem_valid_o, 1'b0);
    check("t5_mem_addr_rst", bus.mem_addr_o, 32'h0);
    check("t5_rvalid_rst", bus.RVALID_o, 1'b0);
    check("t5_bvalid_rst", bus.BVALID_o, 1'b0);
    tick();
    rst = 1'b0;
    mem_hold = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.RVALID_o) n++;
    end
    check("t5_no_rvalid", n, 0);
    check("t5_no_mem_op", op_cnt, base);
    tick();
    mem_wait = 1;
    bus.mem_rdata_i = 32'hCAFEF00D;
    bus.ARADDR_i = 32'h8; bus.ARVALID_i = 1'b1;
    tick();
    bus.ARVALID_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.RVALID_o && n < 20) begin @(negedge clk); n++; end
    check("t5_read_rvalid", bus.RVALID_o, 1'b1);
    check("t5_read_rdata", bus.RDATA_o, 32'hCAFEF00D);
    check("t5_read_addr", op_addr[base[5:0]], 32'h8);
    tick();
    bus.RREADY_i = 1'b1;
    tick();
    bus.RREADY_i = 1'b0;

    // memory never answers a read
    mem_hold = 1'b1;
    bus.ARADDR_i = 32'h300; bus.ARVALID_i = 1'b1;
    tick();
    bus.ARVALID_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.mem_valid_o && n < 100) begin n++; @(negedge clk); end
`ifdef AXIL_SLV_TIMEOUT_EN
    check("t6_mem_valid_cycles", n, 8);
    check("t6_rvalid", bus.RVALID_o, 1'b1);
    check("t6_rresp", bus.RRESP_o, 2'b10);
    check("t6_rdata", bus.RDATA_o, 32'h0);
    tick();
    bus.RREADY_i = 1'b1;
    tick();
    bus.RREADY_i = 1'b0;
`else
    check("t6_mem_valid_cycles", n, 100);
    check("t6_mem_valid_still", bus.mem_valid_o, 1'b1);
    check("t6_no_rvalid", bus.RVALID_o, 1'b0);
`endif
    mem_hold = 1'b0;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
